alu_core: RTL and testbench
===========================

Name: alu_core

Overview:
- 8-bit registered arithmetic/logic unit used by the control unit's execute stage for instructions with IR[11]=1.
- Takes two register-file operands and the 3-bit opcode IR[10:8].
- Produces a result written back to the accumulator REGS[0], plus status flags.
- One-cycle latency with a simple start/valid strobe.

Parameters:
- WIDTH, 8, operand/result width in bits (the control unit uses 8).

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle strobe: sample operands/opcode this cycle
- a  input  WIDTH  first operand (REGS[src])
- b  input  WIDTH  second operand (REGS[dest])
- opcode  input  3  operation select (IR[10:8])
- result  output  WIDTH  registered result (to REGS[0])
- valid  output  1  one-cycle pulse: result/flags updated
- zero  output  1  result == 0
- carry  output  1  carry-out / borrow / shifted-out bit
- negative  output  1  result MSB
- overflow  output  1  signed overflow (ADD/SUB only)

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high.
- Reset (asserted at any time, including mid-operation):
  - result=0, valid=0, zero=0, carry=0, negative=0, overflow=0, immediately.
  - A start sampled in the same edge as reset release is ignored.
- Latency: on a rising edge with start=1, compute from a, b, opcode.
  - Register result and flags; valid=1 for exactly that next cycle.
  - With start=0: result and flags hold, valid=0.
  - Back-to-back starts give back-to-back valid pulses, each reflecting its own operands.
- Opcodes (unsigned modulo 2^WIDTH arithmetic):
  - 000 ADD: result=a+b; carry=bit WIDTH of the (WIDTH+1)-bit sum; overflow=(a[MSB]==b[MSB]) && (result[MSB]!=a[MSB]).
  - 001 SUB: result=a-b; carry=borrow (1 when a<b unsigned); overflow=(a[MSB]!=b[MSB]) && (result[MSB]!=a[MSB]).
  - 010 AND: result=a&b.
  - 011 OR: result=a|b.
  - 100 XOR: result=a^b.
  - 101 NOT: result=~a (b ignored).
  - 110 SHL: result=a<<1, LSB filled 0; carry=a[MSB].
  - 111 SHR: result=a>>1 logical, MSB filled 0; carry=a[0].
- Flags:
  - For logic ops (010-101): carry=0, overflow=0.
  - For shifts: overflow=0.
  - zero and negative are always derived from the new result.
- Flags and result update atomically on the same edge as valid.
- Inputs are don't-care when start=0; no X propagation into outputs while idle.
- Purely synchronous datapath apart from the async reset; no internal state other than output registers.

Decomposition:
- Shared package alu_pkg: WIDTH default, 3-bit opcode enum (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR), and a flags struct {zero, carry, negative, overflow}.
- One natural sub-module: alu_comb, a purely combinational opcode decode plus result/flag computation.
- The alu_core top adds the start/valid register stage and reset.

Test Plan:
- Reset mid-operation: start=1, a=8'h10, b=8'h20, ADD, assert rst asynchronously before the edge → result=0, all flags=0, valid=0 immediately; no valid pulse after release.
- ADD overflow/carry:
  - a=8'h7F, b=8'h01 → result=8'h80, negative=1, overflow=1, carry=0, valid=1 one cycle after start.
  - a=8'hFF, b=8'h01 → result=8'h00, zero=1, carry=1, overflow=0.
- SUB borrow: a=8'h05, b=8'h07 → result=8'hFE, carry=1, negative=1; a=8'h80, b=8'h01 → result=8'h7F, overflow=1, carry=0.
- Logic ops, a=8'hF0, b=8'h3C:
  - AND → 8'h30
  - OR → 8'hFC
  - XOR → 8'hCC
  - NOT → 8'h0F
  - carry=0 and overflow=0 in every case.
- Shifts: SHL a=8'h81 → result=8'h02, carry=1; SHR a=8'h81 → result=8'h40, carry=1; SHR a=8'h01 → result=0, zero=1, carry=1.
- Hold/back-to-back:
  - Two consecutive start cycles (ADD 1+2, then SUB 9-4) → valid high two cycles, result 3 then 5.
  - Then start=0 with changing a/b → result stays 5, valid=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: opcode encoding (IR[10:8]) and status flags.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic negative;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_comb.sv
// Combinational opcode decode plus result and flag computation for alu_core.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    // The extra top bit of the widened difference is the unsigned borrow.
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    result = '0;
    flags  = '0;
    case (alu_op_e'(opcode))
      OP_ADD: begin
        result         = sum[WIDTH-1:0];
        flags.carry    = sum[WIDTH];
        flags.overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result         = diff[WIDTH-1:0];
        flags.carry    = diff[WIDTH];
        flags.overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result      = {a[WIDTH-2:0], 1'b0};
        flags.carry = a[WIDTH-1];
      end
      OP_SHR: begin
        result      = {1'b0, a[WIDTH-1:1]};
        flags.carry = a[0];
      end
      default: ;
    endcase
    flags.zero     = (result == '0);
    flags.negative = result[WIDTH-1];
  end

endmodule

// File: rtl/alu_core.sv
// Registered ALU: samples operands on a start strobe and presents result/flags
// with a one-cycle valid pulse; everything else holds.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow
);

  logic [WIDTH-1:0] comb_result;
  alu_flags_t       comb_flags;

  logic [WIDTH-1:0] result_d, result_q;
  alu_flags_t       flags_d, flags_q;
  logic             valid_d, valid_q;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .a      (a),
    .b      (b),
    .opcode (opcode),
    .result (comb_result),
    .flags  (comb_flags)
  );

  // Idle cycles keep the registers closed so don't-care inputs never reach the outputs.
  always_comb begin
    result_d = result_q;
    flags_d  = flags_q;
    valid_d  = start;
    if (start) begin
      result_d = comb_result;
      flags_d  = comb_flags;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
      valid_q  <= valid_d;
    end
  end

  assign result   = result_q;
  assign valid    = valid_q;
  assign zero     = flags_q.zero;
  assign carry    = flags_q.carry;
  assign negative = flags_q.negative;
  assign overflow = flags_q.overflow;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed vector table, back-to-back/hold and
// reset sequences, and random vectors, all checked through an expected-result queue.
module tb_alu_core;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] res;
    logic       z;
    logic       c;
    logic       n;
    logic       v;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic       z;
    logic       c;
    logic       n;
    logic       v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [2:0] opcode = '0;
  logic [7:0] result;
  logic       valid, zero, carry, negative, overflow;

  int   checks = 0;
  int   errors = 0;
  bit   armed = 1'b0;
  exp_t exp_q[$];
  exp_t last_exp = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
  vec_t vecs[15];

  alu_core #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .opcode   (opcode),
    .result   (result),
    .valid    (valid),
    .zero     (zero),
    .carry    (carry),
    .negative (negative),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference model written with integer arithmetic and range tests.
  function automatic exp_t model(input logic [7:0] ma, input logic [7:0] mb, input logic [2:0] mop);
    exp_t e;
    int   ua, ub, sa, sb, r;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    r  = 0;
    e  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    case (mop)
      3'd0: begin r = ua + ub; e.c = (r > 255); e.v = ((sa + sb) > 127) || ((sa + sb) < -128); end
      3'd1: begin r = ua - ub; e.c = (ua < ub); e.v = ((sa - sb) > 127) || ((sa - sb) < -128); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = 255 - ua;
      3'd6: begin r = ua * 2; e.c = (ua >= 128); end
      default: begin r = ua / 2; e.c = (ua % 2) == 1; end
    endcase
    e.res = r[7:0];
    e.z   = (e.res == 8'h00);
    e.n   = e.res[7];
    return e;
  endfunction

  task automatic compareBit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, got, want, $time);
    end
  endtask

  task automatic compareState(input string tag, input exp_t e);
    checks++;
    if (result !== e.res) begin
      errors++;
      $display("[TB] FAIL %s result: got %h expected %h at %0t", tag, result, e.res, $time);
    end
    compareBit({tag, " zero"}, zero, e.z);
    compareBit({tag, " carry"}, carry, e.c);
    compareBit({tag, " negative"}, negative, e.n);
    compareBit({tag, " overflow"}, overflow, e.v);
  endtask

  // Called just after each rising edge; exp_valid says whether a start was sampled.
  task automatic checkOutput(input logic exp_valid);
    exp_t e;
    compareBit("valid", valid, exp_valid);
    if (exp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard: valid expected but queue empty at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        last_exp = e;
        compareState("op", e);
      end
    end else begin
      compareState("hold", last_exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] iop,
                               input logic istart, input exp_t e);
    @(negedge clk);
    a      = ia;
    b      = ib;
    opcode = iop;
    start  = istart;
    if (istart) exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start  = 1'b0;
      a      = 8'($urandom);
      b      = 8'($urandom);
      opcode = 3'($urandom);
    end
  endtask

  task automatic drainQueue();
    int budget;
    budget = 10;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d results still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  always @(posedge clk) begin
    logic sampled;
    sampled = start && !rst;
    #1;
    if (armed) checkOutput(sampled);
  end

  initial begin
    exp_t e;
    vec_t v;
    logic [7:0] ra, rb;
    logic [2:0] rop;
    logic       rs;

    vecs[0]  = '{8'h7F, 8'h01, 3'd0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{8'h05, 8'h07, 3'd1, 8'hFE, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{8'h80, 8'h01, 3'd1, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{8'hF0, 8'h3C, 3'd2, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{8'hF0, 8'h3C, 3'd3, 8'hFC, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{8'hF0, 8'h3C, 3'd4, 8'hCC, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{8'hF0, 8'h3C, 3'd5, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{8'h81, 8'h00, 3'd6, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{8'h81, 8'h00, 3'd7, 8'h40, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{8'h01, 8'hAA, 3'd7, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{8'h10, 8'h10, 3'd1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{8'h80, 8'h80, 3'd0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{8'h40, 8'h00, 3'd6, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{8'hFF, 8'h55, 3'd5, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compareBit("reset valid", valid, 1'b0);
    compareState("reset", last_exp);
    rst = 1'b0;
    armed = 1'b1;
    $display("[TB] reset released, starting directed vectors");

    // Directed table, alternating back-to-back pairs with idle gaps.
    for (int i = 0; i < 15; i++) begin
      v = vecs[i];
      e = '{v.res, v.z, v.c, v.n, v.v};
      applyStimulus(v.a, v.b, v.op, 1'b1, e);
      if (i % 2 == 1) idle(2);
    end
    idle(2);
    drainQueue();

    // Back-to-back ADD 1+2 then SUB 9-4, followed by idle cycles with wiggling inputs.
    applyStimulus(8'd1, 8'd2, 3'd0, 1'b1, '{8'h03, 1'b0, 1'b0, 1'b0, 1'b0});
    applyStimulus(8'd9, 8'd4, 3'd1, 1'b1, '{8'h05, 1'b0, 1'b0, 1'b0, 1'b0});
    idle(4);
    drainQueue();

    // Asynchronous reset mid-operation: start is up but reset lands before the edge.
    @(negedge clk);
    a      = 8'h10;
    b      = 8'h20;
    opcode = 3'd0;
    start  = 1'b1;
    #2;
    rst = 1'b1;
    last_exp = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    #1;
    compareBit("async reset valid", valid, 1'b0);
    compareState("async reset", last_exp);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    idle(3);

    // Random vectors with random start gaps.
    for (int i = 0; i < 40; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rop = 3'($urandom);
      rs  = 1'($urandom_range(0, 3) != 0);
      applyStimulus(ra, rb, rop, rs, model(ra, rb, rop));
    end
    idle(3);
    drainQueue();

    armed = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] timeout");
  end

endmodule
